// File: rtl/fetch_ctrl.sv
// Fetch-stage PC control: selects the next-PC source, tracks exception-handler mode,
// saves EPC/cause, squashes wrong-path fetches after redirects and runs a stall watchdog.
module fetch_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_LIMIT  = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_branch_taken,
    input  logic        i_eret,
    input  logic        i_exc_req,
    input  logic [4:0]  i_exc_cause,
    input  logic [31:0] i_exc_pc,
    input  logic        i_stall,
    input  logic [31:0] i_fetch_pc,
    output logic [1:0]  o_pcsrc,
    output logic        o_pcWrite,
    output logic [31:0] o_epc,
    output logic [4:0]  o_cause,
    output logic        o_flush,
    output logic        o_exl,
    output logic        o_dbl_fault
);

    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] HANDLER = 1'b1;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_ERET = 2'b10;
    localparam logic [1:0] PC_EXC  = 2'b11;

    localparam logic [2:0] FLUSH_LOAD    = 3'(FLUSH_CYCLES);
    localparam logic [7:0] STALL_MAX     = 8'(STALL_LIMIT - 1);
    localparam logic [4:0] WATCHDOG_CODE = 5'h1F;

    logic [0:0]  r_state;
    logic [31:0] r_epc;
    logic [4:0]  r_cause;
    logic        r_dblFault;
    logic [2:0]  r_flushCnt;
    logic [7:0]  r_stallCnt;

    logic        w_watchdog;
    logic        w_exc;
    logic        w_redirect;
    logic [1:0]  w_pcsrc;
    logic        w_pcWrite;

    // Priority chain; an exception while already in HANDLER falls through to lower events.
    always_comb begin
        w_watchdog = i_stall && (r_stallCnt == STALL_MAX);
        w_exc      = i_exc_req || w_watchdog;
        w_pcsrc    = PC_SEQ;
        w_pcWrite  = 1'b1;
        if (i_rst) begin
            w_pcWrite = 1'b0;
        end else if (w_exc && (r_state == RUN)) begin
            w_pcsrc = PC_EXC;
        end else if (i_eret && (r_state == HANDLER)) begin
            w_pcsrc = PC_ERET;
        end else if (i_branch_taken) begin
            w_pcsrc = PC_BR;
        end else if (i_stall) begin
            w_pcWrite = 1'b0;
        end
        w_redirect = (w_pcsrc != PC_SEQ);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= RUN;
            r_epc      <= '0;
            r_cause    <= '0;
            r_dblFault <= 1'b0;
            r_flushCnt <= '0;
            r_stallCnt <= '0;
        end else begin
            if (w_pcsrc == PC_EXC) begin
                r_state <= HANDLER;
                // External request wins over a coincident watchdog trip.
                r_epc   <= i_exc_req ? i_exc_pc    : i_fetch_pc;
                r_cause <= i_exc_req ? i_exc_cause : WATCHDOG_CODE;
            end else if (w_pcsrc == PC_ERET) begin
                r_state <= RUN;
            end

            if (w_exc && (r_state == HANDLER)) begin
                r_dblFault <= 1'b1;
            end

            if (w_redirect) begin
                r_flushCnt <= FLUSH_LOAD;
            end else if (r_flushCnt != 3'd0) begin
                r_flushCnt <= r_flushCnt - 3'd1;
            end

            if (w_redirect || !i_stall || w_watchdog) begin
                r_stallCnt <= '0;
            end else begin
                r_stallCnt <= r_stallCnt + 8'd1;
            end
        end
    end

    assign o_pcsrc     = w_pcsrc;
    assign o_pcWrite   = w_pcWrite;
    assign o_epc       = r_epc;
    assign o_cause     = r_cause;
    assign o_flush     = (r_flushCnt != 3'd0);
    assign o_exl       = (r_state == HANDLER);
    assign o_dbl_fault = r_dblFault;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: inputs change on the falling edge, outputs are checked
// 1ns later, so registered outputs reflect all earlier rising edges.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        branchTaken;
    logic        eret;
    logic        excReq;
    logic [4:0]  excCause;
    logic [31:0] excPc;
    logic        stall;
    logic [31:0] fetchPc;
    logic [1:0]  pcsrc;
    logic        pcWrite;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic        flush;
    logic        exl;
    logic        dblFault;

    int numChecks = 0;
    int numFails  = 0;

    fetch_ctrl #(.FLUSH_CYCLES(2), .STALL_LIMIT(16)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_branch_taken (branchTaken),
        .i_eret         (eret),
        .i_exc_req      (excReq),
        .i_exc_cause    (excCause),
        .i_exc_pc       (excPc),
        .i_stall        (stall),
        .i_fetch_pc     (fetchPc),
        .o_pcsrc        (pcsrc),
        .o_pcWrite      (pcWrite),
        .o_epc          (epc),
        .o_cause        (cause),
        .o_flush        (flush),
        .o_exl          (exl),
        .o_dbl_fault    (dblFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic br, input logic er, input logic ex,
                                 input logic [4:0] cs, input logic [31:0] xpc,
                                 input logic st, input logic [31:0] fpc);
        @(negedge clk);
        rst         = r;
        branchTaken = br;
        eret        = er;
        excReq      = ex;
        excCause    = cs;
        excPc       = xpc;
        stall       = st;
        fetchPc     = fpc;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; branchTaken = 1'b0; eret = 1'b0; excReq = 1'b0;
        excCause = '0; excPc = '0; stall = 1'b0; fetchPc = '0;

        // Reset with noisy inputs: must be ignored
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'h3, 32'hDEAD, 1'b1, 32'hBEEF);
        checkOutput("rst_pcsrc", 32'(pcsrc), 32'h0);
        checkOutput("rst_pcWrite", 32'(pcWrite), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("rst_epc", epc, 32'h0);
        checkOutput("rst_cause", 32'(cause), 32'h0);
        checkOutput("rst_flush", 32'(flush), 32'h0);
        checkOutput("rst_exl", 32'(exl), 32'h0);
        checkOutput("rst_dbl", 32'(dblFault), 32'h0);

        for (int i = 0; i < 3; i++) begin
            idle();
            checkOutput("idle_pcsrc", 32'(pcsrc), 32'h0);
            checkOutput("idle_pcWrite", 32'(pcWrite), 32'h1);
            checkOutput("idle_flush", 32'(flush), 32'h0);
        end

        // Exception beats simultaneous branch
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 5'h04, 32'h40, 1'b0, 32'h0);
        checkOutput("exc_pcsrc", 32'(pcsrc), 32'h3);
        idle();
        checkOutput("exc_epc", epc, 32'h40);
        checkOutput("exc_cause", 32'(cause), 32'h04);
        checkOutput("exc_exl", 32'(exl), 32'h1);
        checkOutput("exc_flush1", 32'(flush), 32'h1);
        idle();
        checkOutput("exc_flush2", 32'(flush), 32'h1);
        idle();
        checkOutput("exc_flush3", 32'(flush), 32'h0);

        // Return from handler
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("eret_pcsrc", 32'(pcsrc), 32'h2);
        checkOutput("eret_exlHeld", 32'(exl), 32'h1);
        idle();
        checkOutput("eret_exl", 32'(exl), 32'h0);
        checkOutput("eret_flush1", 32'(flush), 32'h1);
        idle();
        checkOutput("eret_flush2", 32'(flush), 32'h1);
        idle();
        checkOutput("eret_flush3", 32'(flush), 32'h0);

        // eret in RUN is ignored
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("eretRun_pcsrc", 32'(pcsrc), 32'h0);
        checkOutput("eretRun_pcWrite", 32'(pcWrite), 32'h1);

        // Re-enter handler, then a nested exception raises double fault
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'h07, 32'h80, 1'b0, 32'h0);
        checkOutput("reenter_pcsrc", 32'(pcsrc), 32'h3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'h09, 32'h200, 1'b0, 32'h0);
        checkOutput("nested_pcsrc", 32'(pcsrc), 32'h0);
        checkOutput("nested_pcWrite", 32'(pcWrite), 32'h1);
        checkOutput("nested_epc", epc, 32'h80);
        idle();
        checkOutput("dbl_set", 32'(dblFault), 32'h1);
        checkOutput("dbl_epc", epc, 32'h80);
        checkOutput("dbl_cause", 32'(cause), 32'h07);
        checkOutput("dbl_flushTail", 32'(flush), 32'h1);
        idle();
        checkOutput("dbl_flushDone", 32'(flush), 32'h0);

        // Branch inside handler keeps state
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("hBr_pcsrc", 32'(pcsrc), 32'h1);
        idle();
        checkOutput("hBr_exl", 32'(exl), 32'h1);
        checkOutput("hBr_flush", 32'(flush), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("hEret_pcsrc", 32'(pcsrc), 32'h2);
        idle();
        checkOutput("hEret_exl", 32'(exl), 32'h0);
        checkOutput("dbl_sticky", 32'(dblFault), 32'h1);
        idle();
        idle();

        // Watchdog: 15 held cycles, exception on the 16th
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0, 1'b1, 32'h100);
            checkOutput("stall_pcWrite", 32'(pcWrite), 32'h0);
            checkOutput("stall_pcsrc", 32'(pcsrc), 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0, 1'b1, 32'h100);
        checkOutput("wdog_pcsrc", 32'(pcsrc), 32'h3);
        idle();
        checkOutput("wdog_cause", 32'(cause), 32'h1F);
        checkOutput("wdog_epc", epc, 32'h100);
        checkOutput("wdog_exl", 32'(exl), 32'h1);

        // Branch overrides stall
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'h0, 32'h0, 1'b1, 32'h0);
        checkOutput("brStall_pcsrc", 32'(pcsrc), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("wdogEret_pcsrc", 32'(pcsrc), 32'h2);
        idle();
        idle();
        idle();
        checkOutput("preBr_flush", 32'(flush), 32'h0);

        // Back-to-back branches reload the flush counter
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("br1_pcsrc", 32'(pcsrc), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("br2_flush", 32'(flush), 32'h1);
        idle();
        checkOutput("br3_flush", 32'(flush), 32'h1);
        idle();
        checkOutput("br4_flush", 32'(flush), 32'h1);
        idle();
        checkOutput("br5_flush", 32'(flush), 32'h0);

        // Reset in handler mid-flush
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'h05, 32'h300, 1'b0, 32'h0);
        checkOutput("pre_rst_pcsrc", 32'(pcsrc), 32'h3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("midRst_exl", 32'(exl), 32'h1);
        checkOutput("midRst_flush", 32'(flush), 32'h1);
        checkOutput("midRst_pcWrite", 32'(pcWrite), 32'h0);
        idle();
        checkOutput("postRst_epc", epc, 32'h0);
        checkOutput("postRst_cause", 32'(cause), 32'h0);
        checkOutput("postRst_flush", 32'(flush), 32'h0);
        checkOutput("postRst_exl", 32'(exl), 32'h0);
        checkOutput("postRst_dbl", 32'(dblFault), 32'h0);
        checkOutput("postRst_pcWrite", 32'(pcWrite), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numChecks, numFails);
        $finish;
    end

endmodule
